gpio_n: RTL

Parametrised GPIO peripheral for the MyCPU SoC, replacing the fixed two-pin `gpio` slave on the RIB. It provides NUM_IO bidirectional pins with per-pin direction control, a multi-flop input synchroniser, edge detection, and a maskable interrupt output. The interrupt feeds the core's `int_i` bus alongside `timer0_int`. Pin tristating stays in the SoC top, driven from `io_out_o` and `io_oe_o`.

---
 rtl/gpio_n.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/gpio_n.sv
// Parametrised GPIO slave: per-pin direction, synchronised inputs, edge/level interrupts.
// Optional input debounce stage is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_n #(
  parameter int NUM_IO       = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        sel_i,
  output logic [31:0]       data_o,
  input  logic [NUM_IO-1:0] io_pin_i,
  output logic [NUM_IO-1:0] io_out_o,
  output logic [NUM_IO-1:0] io_oe_o,
  output logic              int_sig_o
);

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_DATA     = 8'h04;
  localparam logic [7:0] ADDR_INT_EN   = 8'h08;
  localparam logic [7:0] ADDR_INT_TYPE = 8'h0C;
  localparam logic [7:0] ADDR_PEND     = 8'h10;

  typedef enum logic [1:0] {
    EV_RISE  = 2'b00,
    EV_FALL  = 2'b01,
    EV_BOTH  = 2'b10,
    EV_LEVEL = 2'b11
  } ev_type_e;

  logic [2*NUM_IO-1:0]              ctrl_q;
  logic [2*NUM_IO-1:0]              int_type_q;
  logic [NUM_IO-1:0]                out_q;
  logic [NUM_IO-1:0]                int_en_q;
  logic [NUM_IO-1:0]                pend_q;
  logic [NUM_IO-1:0]                prev_q;
  logic [SYNC_STAGES-1:0][NUM_IO-1:0] sync_q;
  logic [NUM_IO-1:0]                sync_out;
  logic [NUM_IO-1:0]                in_w;
  logic [NUM_IO-1:0]                evt;
  logic [NUM_IO-1:0]                pend_clr;
  logic [NUM_IO-1:0]                data_rd;
  logic [31:0]                      wmask;
  logic [31:0]                      wdat;
  logic [7:0]                       addr;
  logic                             unused;

  assign addr     = addr_i[7:0];
  assign wmask    = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
  assign wdat     = data_i & wmask;
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign pend_clr = (we_i && addr == ADDR_PEND) ? wdat[NUM_IO-1:0] : '0;

  // NOTE: every sequential assignment uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q     <= '0;
      int_type_q <= '0;
      out_q      <= '0;
      int_en_q   <= '0;
      pend_q     <= '0;
      prev_q     <= '0;
      sync_q     <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_pin_i};
      prev_q <= in_w;
      // Set has priority over W1C so an event landing with a clear is not lost.
      pend_q <= (pend_q & ~pend_clr) | (evt & int_en_q);
      if (we_i) begin
        unique case (addr)
          ADDR_CTRL:     ctrl_q     <= (ctrl_q & ~wmask[2*NUM_IO-1:0]) | wdat[2*NUM_IO-1:0];
          ADDR_DATA:     out_q      <= (out_q & ~wmask[NUM_IO-1:0]) | wdat[NUM_IO-1:0];
          ADDR_INT_EN:   int_en_q   <= (int_en_q & ~wmask[NUM_IO-1:0]) | wdat[NUM_IO-1:0];
          ADDR_INT_TYPE: int_type_q <= (int_type_q & ~wmask[2*NUM_IO-1:0]) | wdat[2*NUM_IO-1:0];
          default:       ;
        endcase
      end
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [NUM_IO-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_IO-1:0]            in_q;

  // IN follows the synchroniser only after DEBOUNCE_CYC consecutive differing cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      in_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (sync_out[i] != in_q[i]) begin
          if (cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
            in_q[i]  <= sync_out[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign in_w   = in_q;
  assign unused = ^{addr_i[31:8], wmask, wdat};
`else
  assign in_w   = sync_out;
  assign unused = ^{addr_i[31:8], wmask, wdat, 32'(DEBOUNCE_CYC)};
`endif

  // NOTE: combinational blocks assign defaults first so no path infers a latch.
  always_comb begin
    evt     = '0;
    data_rd = '0;
    io_oe_o = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      unique case (ev_type_e'(int_type_q[2*i +: 2]))
        EV_RISE:  evt[i] = in_w[i] & ~prev_q[i];
        EV_FALL:  evt[i] = ~in_w[i] & prev_q[i];
        EV_BOTH:  evt[i] = in_w[i] ^ prev_q[i];
        EV_LEVEL: evt[i] = in_w[i];
        default:  evt[i] = 1'b0;
      endcase
      io_oe_o[i] = (ctrl_q[2*i +: 2] == 2'b01);
      data_rd[i] = io_oe_o[i] ? out_q[i] : in_w[i];
    end
  end

  always_comb begin
    data_o = '0;
    unique case (addr)
      ADDR_CTRL:     data_o = 32'(ctrl_q);
      ADDR_DATA:     data_o = 32'(data_rd);
      ADDR_INT_EN:   data_o = 32'(int_en_q);
      ADDR_INT_TYPE: data_o = 32'(int_type_q);
      ADDR_PEND:     data_o = 32'(pend_q);
      default:       data_o = '0;
    endcase
  end

  assign io_out_o  = out_q;
  assign int_sig_o = |(pend_q & int_en_q);

endmodule
